// File: rtl/multiplier_pkg.sv
// Shared types for the shift-add multiplier pipeline (widths mirror the divider package).
package multiplier_pkg;

    localparam int Q_W = 4;
    localparam int D_W = 2;
    localparam int P_W = Q_W + D_W;

    function automatic int prod_len(input int qw, input int dw);
        return qw + dw;
    endfunction

    typedef struct packed {
        logic             valid;
`ifdef MULTIPLIER_REMCHK_EN
        logic             rem_bad;
`endif
        logic [Q_W-1:0]   q;
        logic [D_W-1:0]   d;
        logic [P_W-1:0]   acc;
    } stage_t;

    // Debug split of the accumulator into upper and lower halves.
    typedef union packed {
        logic [P_W-1:0] flat;
        struct packed {
            logic [P_W-P_W/2-1:0] hi;
            logic [P_W/2-1:0]     lo;
        } half;
    } acc_view_t;

endpackage

// File: rtl/multiplierslice.sv
// One combinational shift-add step: adds d<<SHIFT when quotient bit SHIFT is set.
module multiplierslice
    import multiplier_pkg::*;
#(
    parameter int SHIFT = 0
) (
    input  stage_t cur,
    output stage_t nxt
);

    always_comb begin
        nxt = cur;
        if (cur.q[SHIFT]) begin
            nxt.acc = cur.acc + (P_W'(cur.d) << SHIFT);
        end
    end

endmodule

// File: rtl/multiplier_pipe.sv
// Pipelined shift-add multiplier: dividend = quotient*divisor + remainder.
// Optional MULTIPLIER_REMCHK_EN adds rem_err (remainder >= divisor) travelling with data.
module multiplier_pipe
    import multiplier_pkg::*;
#(
    parameter  int DIVIDENDLEN = Q_W,
    parameter  int DIVISORLEN  = D_W,
    localparam int PRODLEN     = prod_len(DIVIDENDLEN, DIVISORLEN)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DIVIDENDLEN-1:0] quotient,
    input  logic [DIVISORLEN-1:0]  divisor,
    input  logic [DIVISORLEN-1:0]  remainder,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PRODLEN-1:0]     dividend
`ifdef MULTIPLIER_REMCHK_EN
    ,
    output logic                   rem_err
`endif
);

    localparam int LAST = DIVIDENDLEN - 1;

    stage_t entry;
    stage_t cur [DIVIDENDLEN];
    stage_t nxt [DIVIDENDLEN];
    stage_t stg [DIVIDENDLEN];
    logic   stall;

    always_comb begin
        entry       = '0;
        entry.valid = in_valid;
        entry.q     = quotient;
        entry.d     = divisor;
        entry.acc   = PRODLEN'(remainder);
`ifdef MULTIPLIER_REMCHK_EN
        entry.rem_bad = (remainder >= divisor);
`endif
    end

    for (genvar k = 0; k < DIVIDENDLEN; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign cur[k] = entry;
        end else begin : g_body
            assign cur[k] = stg[k-1];
        end
        multiplierslice #(.SHIFT(k)) u_slice (
            .cur (cur[k]),
            .nxt (nxt[k])
        );
    end

    // Global stall freezes every stage; bubbles travel through unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DIVIDENDLEN; k++) begin
                stg[k] <= '0;
            end
        end else if (!stall) begin
            for (int k = 1; k < DIVIDENDLEN; k++) begin
                stg[k] <= nxt[k];
            end
            if (in_valid) begin
                stg[0] <= nxt[0];
            end else begin
                stg[0].valid <= 1'b0;
            end
        end
    end

    assign out_valid = stg[LAST].valid;
    assign stall     = out_valid && !out_ready;
    assign in_ready  = !stall;
    assign dividend  = out_valid ? stg[LAST].acc : '0;

`ifdef MULTIPLIER_REMCHK_EN
    assign rem_err = out_valid && stg[LAST].rem_bad;
`endif

endmodule
